// File: rtl/dtg_param.sv
// dtg_param: parametrised display timing generator with pixel-clock
// enable, programmable sync polarity and an output alignment delay.
module dtg_param #(
   parameter int unsigned CW       = 12,
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 128,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 9,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 29,
   parameter int unsigned HS_POL   = 0,
   parameter int unsigned VS_POL   = 0,
   parameter int unsigned PIPE     = 2
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              pix_en,
   output logic [CW-1:0]     pixel_column,
   output logic [CW-1:0]     pixel_row,
   output logic [ADDR_W-1:0] pix_num,
   output logic              horiz_sync,
   output logic              vert_sync,
   output logic              video_on,
   output logic              line_start,
   output logic              frame_start,
   output logic [15:0]       frame_count
);

   localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
   localparam logic [CW-1:0] V_ALST = CW'(V_ACTIVE - 1);

   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   if (longint'(HT) > (longint'(1) << CW) ||
       longint'(VT) > (longint'(1) << CW)) begin : g_bad_cw
      $error("dtg_param: CW too small for HT/VT");
   end

   if (longint'(H_ACTIVE) * longint'(V_ACTIVE) >
       (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("dtg_param: ADDR_W too small for active area");
   end

   if (PIPE > 7) begin : g_bad_pipe
      $error("dtg_param: PIPE must be 0..7");
   end

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 ||
       V_BP == 0) begin : g_bad_seg
      $error("dtg_param: timing segments must be non-zero");
   end

   logic [CW-1:0]     col_q, col_d;
   logic [CW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [15:0]       fc_q, fc_d;

   logic col_wrap, row_wrap;
   logic active, hs_raw, vs_raw;

   always_comb begin
      col_wrap = (col_q == H_LAST);
      row_wrap = (row_q == V_LAST);
      active   = (col_q < H_ACT) && (row_q < V_ACT);
      hs_raw   = (col_q >= H_SS) && (col_q < H_SE);
      vs_raw   = (row_q >= V_SS) && (row_q < V_SE);
   end

   // pix_num tracks row*H_ACTIVE+col without a multiplier: it only
   // counts active pixels and is cleared when leaving the last active row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      pix_d = pix_q;
      fc_d  = fc_q;
      if (pix_en) begin
         col_d = col_wrap ? '0 : col_q + 1'b1;
         if (col_wrap) begin
            row_d = row_wrap ? '0 : row_q + 1'b1;
            if (row_wrap) begin
               fc_d = fc_q + 1'b1;
            end
         end
         if (col_wrap && row_q == V_ALST) begin
            pix_d = '0;
         end else if (active) begin
            pix_d = pix_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
         pix_q <= '0;
         fc_q  <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         pix_q <= pix_d;
         fc_q  <= fc_d;
      end
   end

   logic [2:0] raw;
   logic [2:0] dly;

   assign raw = {active, hs_raw, vs_raw};

   if (PIPE == 0) begin : g_nodly
      assign dly = raw;
   end else begin : g_dly
      logic [2:0] sr_q [PIPE];

      always_ff @(posedge clock) begin
         if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
               sr_q[i] <= '0;
            end
         end else if (pix_en) begin
            sr_q[0] <= raw;
            for (int i = 1; i < PIPE; i++) begin
               sr_q[i] <= sr_q[i-1];
            end
         end
      end

      assign dly = sr_q[PIPE-1];
   end

   assign pixel_column = col_q;
   assign pixel_row    = row_q;
   assign pix_num      = pix_q;
   assign frame_count  = fc_q;
   assign video_on     = dly[2];
   assign horiz_sync   = dly[1] ? HS_ON : ~HS_ON;
   assign vert_sync    = dly[0] ? VS_ON : ~VS_ON;
   assign line_start   = pix_en && (col_q == '0) && (row_q < V_ACT);
   assign frame_start  = pix_en && (col_q == '0) && (row_q == '0);

endmodule
